// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg -- shared constants and types for the SRAM loader.
//
// Holds the bus/address width constants, the SRAM depth constants, the
// destination-target encoding and the loader FSM state type. Imported by the
// loader interface and the loader top.
// -----------------------------------------------------------------------------
package loader_pkg;

    // Data word width and per-SRAM address widths.
    localparam int DW    = 16;
    localparam int AW1   = 18;   // weight-1 SRAM
    localparam int AW2   = 12;   // weight-2 SRAM
    localparam int AW3   = 10;   // input SRAM (shared row address)
    localparam int LANES = 10;   // input SRAM lanes

    // SRAM depths in words.
    localparam int DEPTH1 = 1 << AW1;
    localparam int DEPTH2 = 1 << AW2;
    localparam int DEPTH3 = 1 << AW3;

    // Width of the input-bank lane counter (counts 0..LANES-1).
    localparam int LANE_W = $clog2(LANES);

    // Destination target encoding.
    localparam logic [1:0] TGT_W1  = 2'd0;
    localparam logic [1:0] TGT_W2  = 2'd1;
    localparam logic [1:0] TGT_IN  = 2'd2;
    localparam logic [1:0] TGT_BAD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sram_loader_if.sv
// -----------------------------------------------------------------------------
// sram_loader_if -- command, stream and SRAM write-port bundle of the loader.
//
// Command : start, target[1:0], base[AW1-1:0], len[AW1-1:0]
// Stream  : in_valid, in_data[DW-1:0] (to loader), in_ready (from loader)
// Weight-1: we_1, address_1[AW1-1:0], dw1[DW-1:0]
// Weight-2: we_2, address_2[AW2-1:0], dw2[DW-1:0]
// Input   : we_3[LANES-1:0] (one-hot lane enable), address_3[AW3-1:0], d_in
// Status  : busy, done (1-cycle pulse), err (1-cycle pulse)
//
// master modport: the controller/source side. slave modport: the loader.
// -----------------------------------------------------------------------------
interface sram_loader_if #(
    parameter int DW    = loader_pkg::DW,
    parameter int AW1   = loader_pkg::AW1,
    parameter int AW2   = loader_pkg::AW2,
    parameter int AW3   = loader_pkg::AW3,
    parameter int LANES = loader_pkg::LANES
);

    logic             start;
    logic [1:0]       target;
    logic [AW1-1:0]   base;
    logic [AW1-1:0]   len;

    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             in_ready;

    logic             we_1;
    logic [AW1-1:0]   address_1;
    logic [DW-1:0]    dw1;

    logic             we_2;
    logic [AW2-1:0]   address_2;
    logic [DW-1:0]    dw2;

    logic [LANES-1:0] we_3;
    logic [AW3-1:0]   address_3;
    logic [DW-1:0]    d_in;

    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, target, base, len, in_valid, in_data,
        input  in_ready,
        input  we_1, address_1, dw1,
        input  we_2, address_2, dw2,
        input  we_3, address_3, d_in,
        input  busy, done, err
    );

    modport slave (
        input  start, target, base, len, in_valid, in_data,
        output in_ready,
        output we_1, address_1, dw1,
        output we_2, address_2, dw2,
        output we_3, address_3, d_in,
        output busy, done, err
    );

endinterface

// File: rtl/sram_loader.sv
// -----------------------------------------------------------------------------
// sram_loader -- streams a block of words into one of three SRAMs.
//
// Ports:
//   clk   : sole clock, rising edge.
//   reset : synchronous, active-low.
//   bus   : sram_loader_if.slave -- command (start/target/base/len), input
//           stream (in_valid/in_data/in_ready), three SRAM write ports and
//           status (busy/done/err).
//
// A start in IDLE captures the command. Each word accepted in LOAD produces a
// registered write on the selected port one cycle later. Weight targets write
// to base+k; the input bank writes word k to lane k%LANES at row
// base+k/LANES, tracked with a lane/row counter pair instead of a divider.
// The final accept moves to FLUSH, where its write appears, then DONE pulses
// done for one cycle and the FSM returns to IDLE.
// -----------------------------------------------------------------------------
module sram_loader
    import loader_pkg::*;
#(
    parameter int DW    = loader_pkg::DW,
    parameter int AW1   = loader_pkg::AW1,
    parameter int AW2   = loader_pkg::AW2,
    parameter int AW3   = loader_pkg::AW3,
    parameter int LANES = loader_pkg::LANES
) (
    input  logic         clk,
    input  logic         reset,
    sram_loader_if.slave bus
);

    localparam int LW = $clog2(LANES);

    state_e           state_q;
    logic [1:0]       tgt_q;
    logic [AW1-1:0]   len_q;
    logic [AW1-1:0]   cnt_q;      // words accepted so far
    logic [AW1-1:0]   wt_addr_q;  // next weight address (truncated per target)
    logic [AW3-1:0]   row_q;      // next input-bank row
    logic [LW-1:0]    lane_q;     // next input-bank lane, 0..LANES-1

    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             we_1_q;
    logic [AW1-1:0]   address_1_q;
    logic [DW-1:0]    dw1_q;
    logic             we_2_q;
    logic [AW2-1:0]   address_2_q;
    logic [DW-1:0]    dw2_q;
    logic [LANES-1:0] we_3_q;
    logic [AW3-1:0]   address_3_q;
    logic [DW-1:0]    d_in_q;

    logic             accept;
    logic             last_word;

    assign accept    = (state_q == ST_LOAD) && bus.in_valid;
    assign last_word = (cnt_q == len_q - 1'b1);

    always_ff @(posedge clk) begin
        // NOTE: every state element here uses <= so all registers see the
        // values from before this edge; mixing in = would make the result
        // depend on statement order.
        if (!reset) begin
            state_q     <= ST_IDLE;
            tgt_q       <= TGT_W1;
            len_q       <= '0;
            cnt_q       <= '0;
            wt_addr_q   <= '0;
            row_q       <= '0;
            lane_q      <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            we_1_q      <= 1'b0;
            address_1_q <= '0;
            dw1_q       <= '0;
            we_2_q      <= 1'b0;
            address_2_q <= '0;
            dw2_q       <= '0;
            we_3_q      <= '0;
            address_3_q <= '0;
            d_in_q      <= '0;
        end else begin
            // Pulse outputs default low; the states below raise them for
            // exactly one cycle.
            we_1_q <= 1'b0;
            we_2_q <= 1'b0;
            we_3_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.target == TGT_BAD) begin
                            err_q <= 1'b1;
                        end else if (bus.len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            tgt_q      <= bus.target;
                            len_q      <= bus.len;
                            cnt_q      <= '0;
                            wt_addr_q  <= bus.base;
                            row_q      <= bus.base[AW3-1:0];
                            lane_q     <= '0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= ST_LOAD;
                        end
                    end
                end

                ST_LOAD: begin
                    if (accept) begin
                        unique case (tgt_q)
                            TGT_W2: begin
                                we_2_q      <= 1'b1;
                                address_2_q <= wt_addr_q[AW2-1:0];
                                dw2_q       <= bus.in_data;
                                wt_addr_q   <= wt_addr_q + 1'b1;
                            end
                            TGT_IN: begin
                                we_3_q      <= LANES'(1) << lane_q;
                                address_3_q <= row_q;
                                d_in_q      <= bus.in_data;
                                // Row advances only when the lane wraps.
                                if (lane_q == LW'(LANES - 1)) begin
                                    lane_q <= '0;
                                    row_q  <= row_q + 1'b1;
                                end else begin
                                    lane_q <= lane_q + 1'b1;
                                end
                            end
                            default: begin
                                we_1_q      <= 1'b1;
                                address_1_q <= wt_addr_q;
                                dw1_q       <= bus.in_data;
                                wt_addr_q   <= wt_addr_q + 1'b1;
                            end
                        endcase
                        cnt_q <= cnt_q + 1'b1;
                        if (last_word) begin
                            in_ready_q <= 1'b0;
                            state_q    <= ST_FLUSH;
                        end
                    end
                end

                // The last word's write is on the ports during this cycle.
                ST_FLUSH: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.we_1      = we_1_q;
    assign bus.address_1 = address_1_q;
    assign bus.dw1       = dw1_q;
    assign bus.we_2      = we_2_q;
    assign bus.address_2 = address_2_q;
    assign bus.dw2       = dw2_q;
    assign bus.we_3      = we_3_q;
    assign bus.address_3 = address_3_q;
    assign bus.d_in      = d_in_q;

endmodule

// File: tb/tb_sram_loader.sv
// -----------------------------------------------------------------------------
// tb_sram_loader -- directed self-checking bench for sram_loader.
// Inputs are driven 1 ns after the rising edge; outputs are sampled there and
// the write log is captured on the falling edge.
// -----------------------------------------------------------------------------
module tb_sram_loader;
    import loader_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_loader_if bus ();

    sram_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Write log and event counters.
    logic [AW1+DW-1:0]       q1[$];
    logic [AW2+DW-1:0]       q2[$];
    logic [LANES+AW3+DW-1:0] q3[$];
    int done_cnt = 0;
    int err_cnt  = 0;
    int multi_we = 0;

    always @(negedge clk) begin
        if (bus.we_1 === 1'b1) q1.push_back({bus.address_1, bus.dw1});
        if (bus.we_2 === 1'b1) q2.push_back({bus.address_2, bus.dw2});
        if (bus.we_3 != '0)    q3.push_back({bus.we_3, bus.address_3, bus.d_in});
        if ((int'(bus.we_1) + int'(bus.we_2) + $countones(bus.we_3)) > 1) multi_we++;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.err === 1'b1)  err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] tgt, input logic [AW1-1:0] b,
                               input logic [AW1-1:0] n);
        bus.start  = 1'b1;
        bus.target = tgt;
        bus.base   = b;
        bus.len    = n;
        tick();
        bus.start  = 1'b0;
    endtask

    // Offer n consecutive words d0, d0+1, ... with valid held high.
    task automatic feed_cont(input int n, input logic [DW-1:0] d0);
        int   acc;
        int   guard;
        logic rdy;
        acc   = 0;
        guard = 0;
        bus.in_data = d0;
        while (acc < n && guard < 200) begin
            bus.in_valid = 1'b1;
            rdy = bus.in_ready;
            tick();
            if (rdy) begin
                acc++;
                bus.in_data = bus.in_data + 1'b1;
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        check("feed_accepted", 64'(acc), 64'(n));
    endtask

    initial begin
        logic [AW1-1:0]   exp_a1[4];
        logic [LANES-1:0] oh;
        logic [63:0]      e;
        int               dc0;
        int               ec0;

        exp_a1 = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};

        bus.start    = 1'b0;
        bus.target   = 2'd0;
        bus.base     = '0;
        bus.len      = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // ---------------- reset state ----------------
        reset = 1'b0;
        tick();
        tick();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_busy",     bus.busy, 0);
        check("rst_done",     bus.done, 0);
        check("rst_err",      bus.err, 0);
        check("rst_we",       {bus.we_1, bus.we_2, bus.we_3}, 0);
        check("rst_addr",     {bus.address_1, bus.address_2, bus.address_3}, 0);
        check("rst_data",     {bus.dw1, bus.dw2, bus.d_in}, 0);
        reset = 1'b1;
        tick();

        // ---------------- weight-1 with address wrap ----------------
        q1.delete();
        pulse_start(TGT_W1, 18'h3FFFE, 18'd4);
        check("w1_busy_load",  bus.busy, 1);
        check("w1_ready_load", bus.in_ready, 1);
        feed_cont(4, 16'd1);
        check("w1_ready_flush", bus.in_ready, 0);
        check("w1_last_we",     bus.we_1, 1);
        check("w1_last_addr",   bus.address_1, 18'h00001);
        check("w1_done_early",  bus.done, 0);
        tick();
        check("w1_done",        bus.done, 1);
        check("w1_busy_done",   bus.busy, 0);
        tick();
        check("w1_done_pulse",  bus.done, 0);
        check("w1_nwrites",     q1.size(), 4);
        for (int k = 0; k < 4; k++) begin
            e = 64'({exp_a1[k], 16'(k + 1)});
            check($sformatf("w1_wr%0d", k), 64'(q1[k]), e);
        end

        // ---------------- input bank, 23 words ----------------
        q3.delete();
        pulse_start(TGT_IN, 18'd5, 18'd23);
        feed_cont(23, 16'h0100);
        tick();
        check("in_done",    bus.done, 1);
        check("in_nwrites", q3.size(), 23);
        for (int k = 0; k < 23; k++) begin
            oh = '0;
            oh[k % 10] = 1'b1;
            e = 64'({oh, AW3'(5 + k / 10), DW'(16'h0100 + k)});
            check($sformatf("in_wr%0d", k), 64'(q3[k]), e);
        end
        check("in_onehot", multi_we, 0);
        tick();

        // ---------------- weight-2 with stalls, ignored start, extra word ----
        q2.delete();
        ec0 = err_cnt;
        pulse_start(TGT_W2, 18'h3FFFF, 18'd3);
        bus.in_valid = 1'b1; bus.in_data = 16'h00A0;
        tick();
        check("w2_we_a", bus.we_2, 1);
        check("w2_addr_a", bus.address_2, 12'hFFF);
        bus.in_valid = 1'b0;
        bus.start = 1'b1; bus.target = TGT_BAD; bus.len = 18'd0;
        tick();
        bus.start = 1'b0;
        check("w2_stall_we1", bus.we_2, 0);
        check("w2_ign_err",   bus.err, 0);
        check("w2_busy_stall", bus.busy, 1);
        tick();
        check("w2_stall_we2", bus.we_2, 0);
        bus.in_valid = 1'b1; bus.in_data = 16'h00A1;
        tick();
        check("w2_addr_b", bus.address_2, 12'h000);
        bus.in_data = 16'h00A2;
        tick();
        check("w2_flush_ready", bus.in_ready, 0);
        check("w2_addr_c", bus.address_2, 12'h001);
        bus.in_data = 16'hDEAD;
        tick();
        bus.in_valid = 1'b0;
        check("w2_done", bus.done, 1);
        check("w2_done_we", bus.we_2, 0);
        tick();
        check("w2_nwrites", q2.size(), 3);
        check("w2_wr0", 64'(q2[0]), 64'({12'hFFF, 16'h00A0}));
        check("w2_wr1", 64'(q2[1]), 64'({12'h000, 16'h00A1}));
        check("w2_wr2", 64'(q2[2]), 64'({12'h001, 16'h00A2}));
        check("w2_no_err", err_cnt - ec0, 0);

        // ---------------- len=0 and illegal target ----------------
        q1.delete(); q2.delete(); q3.delete();
        pulse_start(TGT_W1, 18'd0, 18'd0);
        check("len0_done", bus.done, 1);
        check("len0_busy", bus.busy, 0);
        tick();
        check("len0_done_pulse", bus.done, 0);
        pulse_start(TGT_BAD, 18'd7, 18'd5);
        check("bad_err",  bus.err, 1);
        check("bad_busy", bus.busy, 0);
        tick();
        check("bad_err_pulse", bus.err, 0);
        check("bad_ready", bus.in_ready, 0);
        check("len0_bad_nowrite", q1.size() + q2.size() + q3.size(), 0);

        // ---------------- reset mid-load, then a fresh load ----------------
        pulse_start(TGT_W1, 18'h10, 18'd5);
        feed_cont(2, 16'h0050);
        dc0 = done_cnt;
        reset = 1'b0;
        tick();
        check("mid_rst_we",    bus.we_1, 0);
        check("mid_rst_addr",  bus.address_1, 0);
        check("mid_rst_data",  bus.dw1, 0);
        check("mid_rst_ready", bus.in_ready, 0);
        check("mid_rst_busy",  bus.busy, 0);
        reset = 1'b1;
        tick();
        tick();
        check("mid_rst_nodone", done_cnt - dc0, 0);
        check("mid_rst_nwrites", q1.size(), 2);
        q1.delete();
        pulse_start(TGT_W1, 18'h20, 18'd2);
        feed_cont(2, 16'h0077);
        tick();
        check("post_rst_done", bus.done, 1);
        tick();
        check("post_rst_nwrites", q1.size(), 2);
        check("post_rst_wr0", 64'(q1[0]), 64'({18'h20, 16'h0077}));
        check("post_rst_wr1", 64'(q1[1]), 64'({18'h21, 16'h0078}));
        check("all_onehot", multi_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_loader.md
SRAM_LOADER -- requirements
Module: sram_loader

Interface
REQ-001 Parameters SHALL be: DW=16, data word width; AW1=18, weight-1 SRAM address width; AW2=12, weight-2 SRAM address width; AW3=10, input SRAM address width; LANES=10, number of input SRAM lanes.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset  in  1  one clock; reset is synchronous and active-low.
REQ-004 start  in  1  one-cycle load request, sampled only in IDLE.
REQ-005 target  in  2  destination: 0=weight1, 1=weight2, 2=input bank, 3=illegal.
REQ-006 base  in  18  first word address; upper bits are truncated to the target's width.
REQ-007 len  in  18  number of words to load; 0 is legal.
REQ-008 in_valid  in  1  source holds a valid word.
REQ-009 in_data  in  16  word from source.
REQ-010 in_ready  out  1  loader accepts the word this cycle.
REQ-011 we_1, address_1[17:0], dw1[15:0]  out  weight-1 SRAM write port.
REQ-012 we_2, address_2[11:0], dw2[15:0]  out  weight-2 SRAM write port.
REQ-013 we_3[9:0], address_3[9:0], d_in[15:0]  out  input SRAM write port with one-hot per-lane enable; data and address are shared by all lanes.
REQ-014 busy  out  1  high from the cycle after an accepted start until done.
REQ-015 done  out  1  one-cycle pulse when a load completes.
REQ-016 err  out  1  one-cycle pulse when start carries target=3.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, FLUSH, DONE.
REQ-018 IDLE + start + target<3 + len>0: capture target/base/len, go to LOAD.
REQ-019 IDLE + start + target<3 + len=0: go to DONE with no write.
REQ-020 IDLE + start + target=3: err=1 the next cycle, stay IDLE, no write.
REQ-021 start outside IDLE SHALL be ignored, with no err.
REQ-022 in_ready SHALL be 1 only in LOAD; a word is accepted when in_valid&&in_ready.
REQ-023 Word accepted in cycle t: exactly one write enable high in cycle t+1, with registered address and data; no combinational path from in_valid to any we.
REQ-024 Weight targets: word k SHALL go to address base+k, wrapping modulo 2^AW1 or 2^AW2.
REQ-025 Input target: word k SHALL go to lane k mod 10 (we_3 bit k mod 10) at address_3 = base + floor(k/10), wrapping modulo 1024.
REQ-026 The input target SHALL use a lane counter 0..9 that increments the row address on 9→0; no divider.
REQ-027 Acceptance of word len-1 in LOAD SHALL move the FSM to FLUSH; the final write occurs in FLUSH; FLUSH→DONE; DONE→IDLE.
REQ-028 done=1 for exactly the DONE cycle; busy=0 in DONE and IDLE.
REQ-029 in_valid=0 in LOAD SHALL stall with no write and no counter change.
REQ-030 Unused target write ports SHALL hold we=0; address and data are don't-care while we=0.

Reset
REQ-031 reset=0 at a clock edge SHALL set state=IDLE, all we=0, all addresses/data=0, in_ready=0, busy=0, done=0, err=0, and counters=0.
REQ-032 Reset mid-load SHALL abandon the load without a done pulse; SRAM contents already written are untouched.

Structure
REQ-033 Package loader_pkg SHALL hold the target encoding constants, the FSM state enum, the AW1/AW2/AW3/LANES/DW constants, and the depth constants.
REQ-034 Single flat module, no sub-module; the lane/row counter SHALL be inline.

Verification
REQ-035 target=0, base=0x3FFFE, len=4, data 1..4 with continuous valid → we_1 high 4 cycles at addresses 3FFFE, 3FFFF, 00000, 00001; done 2 cycles after the last accept.
REQ-036 target=2, base=5, len=23 → lanes 0..9 at address 5, 0..9 at 6, 0..2 at 7; exactly one we_3 bit high per write.
REQ-037 target=1, len=3, in_valid toggling 1,0,0,1,1 → exactly 3 writes to addresses base..base+2; no write in stall cycles.
REQ-038 start with len=0 → done 1 cycle later, no we; start with target=3 → err pulse, busy stays 0.
REQ-039 reset low after 2 of 5 words → all outputs 0 next cycle, no done; a following load of len=2 completes normally.
REQ-040 start pulsed during LOAD → ignored; in_ready deasserts in FLUSH, so an extra word offered there is not accepted.
